// File: rtl/call_stack_ctrl_pkg.sv
// Shared constants and types for the return-address stack controller.
// Contents:
//   LANES, DEPTH, IP_WIDTH, PTR_W, CNT_W : front-end widths used by the RAS
//   ckpt_t                               : {tos,cnt} packing stored per branch
//   clampCnt()                           : limits an occupancy value to DEPTH
package call_stack_ctrl_pkg;

    localparam int LANES    = 2;
    localparam int DEPTH    = 16;
    localparam int IP_WIDTH = 48;
    localparam int PTR_W    = 4;
    localparam int CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [CNT_W-1:0] cnt;
    } ckpt_t;

    // A restored occupancy larger than the stack is meaningless; cap it.
    function automatic logic [CNT_W-1:0] clampCnt(input logic [CNT_W-1:0] c);
        if (c > CNT_W'(DEPTH)) begin
            clampCnt = CNT_W'(DEPTH);
        end else begin
            clampCnt = c;
        end
    endfunction

endpackage

// File: rtl/call_stack_ctrl_if.sv
// Bus between the front end (master) and the return-address stack (slave).
// Inputs to the stack: stall, per-lane vld/push/pop/ret_ip, restore request.
// Outputs of the stack: checkpoint {tos,cnt}, per-lane predictions, underflow.
interface call_stack_ctrl_if;
    import call_stack_ctrl_pkg::*;

    logic                      stall;
    logic [LANES-1:0]          ln_vld;
    logic [LANES-1:0]          ln_push;
    logic [LANES-1:0]          ln_pop;
    logic [LANES*IP_WIDTH-1:0] ln_ret_ip;
    logic                      restore_en;
    logic [PTR_W-1:0]          restore_tos;
    logic [CNT_W-1:0]          restore_cnt;
    logic [PTR_W-1:0]          ckpt_tos;
    logic [CNT_W-1:0]          ckpt_cnt;
    logic [LANES-1:0]          pred_vld;
    logic [LANES*IP_WIDTH-1:0] pred_ip;
    logic                      underflow;

    modport master (
        output stall, ln_vld, ln_push, ln_pop, ln_ret_ip,
               restore_en, restore_tos, restore_cnt,
        input  ckpt_tos, ckpt_cnt, pred_vld, pred_ip, underflow
    );

    modport slave (
        input  stall, ln_vld, ln_push, ln_pop, ln_ret_ip,
               restore_en, restore_tos, restore_cnt,
        output ckpt_tos, ckpt_cnt, pred_vld, pred_ip, underflow
    );

endinterface

// File: rtl/call_stack_ram.sv
// DEPTH x IP_WIDTH register file holding return IPs.
// Ports: clk; per-lane write enable/address/data (higher lane wins on a
// shared address); per-lane asynchronous read address/data.
// Contents are deliberately not reset.
module call_stack_ram
    import call_stack_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                wrEn   [LANES],
    input  logic [PTR_W-1:0]    wrAddr [LANES],
    input  logic [IP_WIDTH-1:0] wrData [LANES],
    input  logic [PTR_W-1:0]    rdAddr [LANES],
    output logic [IP_WIDTH-1:0] rdData [LANES]
);

    logic [IP_WIDTH-1:0] memR [DEPTH];

    // Write ports applied in lane order so the youngest lane's write lands last.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wrEn[i]) begin
                memR[wrAddr[i]] <= wrData[i];
            end
        end
    end

    // Asynchronous read ports.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rdData[i] = memR[rdAddr[i]];
        end
    end

endmodule

// File: rtl/call_stack_ctrl.sv
// Return-address stack controller.
// Ports: clk, rst (synchronous, active-high), bus (call_stack_ctrl_if.slave).
// Lanes are applied oldest first through a tos/cnt chain; pops read the RAM
// or, when an older lane pushed that slot this cycle, that lane's ret IP.
// Predictions and underflow are registered; the checkpoint is the live tos/cnt.
module call_stack_ctrl
    import call_stack_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    call_stack_ctrl_if.slave bus
);

    logic [PTR_W-1:0]          tosR;
    logic [CNT_W-1:0]          cntR;
    logic [LANES-1:0]          predVldR;
    logic [LANES*IP_WIDTH-1:0] predIpR;
    logic                      underflowR;

    logic [PTR_W-1:0]    tosS;
    logic [CNT_W-1:0]    cntS;
    logic                laneActiveS;
    logic                wrEnS   [LANES];
    logic [PTR_W-1:0]    wrAddrS [LANES];
    logic [IP_WIDTH-1:0] wrDataS [LANES];
    logic [PTR_W-1:0]    rdAddrS [LANES];
    logic [IP_WIDTH-1:0] rdDataS [LANES];
    logic [IP_WIDTH-1:0] predIpS [LANES];
    logic [LANES-1:0]    predVldS;
    logic                underflowS;
    ckpt_t               ckptS;

    assign laneActiveS = !rst && !bus.restore_en && !bus.stall;

    // Lane-serial stack pointer chain: each lane sees the tos/cnt left by older lanes.
    always_comb begin
        tosS       = tosR;
        cntS       = cntR;
        predVldS   = '0;
        underflowS = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            wrEnS[i]   = 1'b0;
            wrAddrS[i] = '0;
            wrDataS[i] = bus.ln_ret_ip[i*IP_WIDTH +: IP_WIDTH];
            rdAddrS[i] = '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (laneActiveS && bus.ln_vld[i]) begin
                // Pop before push so a call+ret lane replaces the top entry.
                if (bus.ln_pop[i]) begin
                    if (cntS != CNT_W'(0)) begin
                        rdAddrS[i]  = tosS;
                        predVldS[i] = 1'b1;
                        tosS        = tosS - PTR_W'(1);
                        cntS        = cntS - CNT_W'(1);
                    end else begin
                        underflowS = 1'b1;
                    end
                end else begin
                    rdAddrS[i] = '0;
                end
                if (bus.ln_push[i]) begin
                    tosS       = tosS + PTR_W'(1);
                    wrEnS[i]   = 1'b1;
                    wrAddrS[i] = tosS;
                    if (cntS != CNT_W'(DEPTH)) begin
                        cntS = cntS + CNT_W'(1);
                    end else begin
                        cntS = cntS;
                    end
                end else begin
                    wrEnS[i] = 1'b0;
                end
            end else begin
                predVldS[i] = 1'b0;
            end
        end
    end

    // Prediction mux: youngest older lane that wrote the popped slot this cycle wins over the RAM.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (predVldS[i]) begin
                predIpS[i] = rdDataS[i];
                for (int j = 0; j < i; j++) begin
                    predIpS[i] = (wrEnS[j] && (wrAddrS[j] == rdAddrS[i])) ? wrDataS[j] : predIpS[i];
                end
            end else begin
                predIpS[i] = '0;
            end
        end
    end

    call_stack_ram u_ram (
        .clk    (clk),
        .wrEn   (wrEnS),
        .wrAddr (wrAddrS),
        .wrData (wrDataS),
        .rdAddr (rdAddrS),
        .rdData (rdDataS)
    );

    // State and output registers: reset beats restore, restore beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            tosR       <= '0;
            cntR       <= '0;
            predVldR   <= '0;
            predIpR    <= '0;
            underflowR <= 1'b0;
        end else if (bus.restore_en) begin
            tosR       <= bus.restore_tos;
            cntR       <= clampCnt(bus.restore_cnt);
            predVldR   <= '0;
            predIpR    <= '0;
            underflowR <= 1'b0;
        end else if (!bus.stall) begin
            tosR       <= tosS;
            cntR       <= cntS;
            predVldR   <= predVldS;
            underflowR <= underflowS;
            for (int i = 0; i < LANES; i++) begin
                predIpR[i*IP_WIDTH +: IP_WIDTH] <= predIpS[i];
            end
        end
    end

    assign ckptS         = '{tos: tosR, cnt: cntR};
    assign bus.ckpt_tos  = ckptS.tos;
    assign bus.ckpt_cnt  = ckptS.cnt;
    assign bus.pred_vld  = predVldR;
    assign bus.pred_ip   = predIpR;
    assign bus.underflow = underflowR;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural stack model (array + integer tos/cnt).
module tb_call_stack_ctrl;
    import call_stack_ctrl_pkg::*;

    logic clk;
    logic rst;
    call_stack_ctrl_if busIf ();

    call_stack_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec;
    int nErr;

    // behavioural model
    int           mTos;
    int           mCnt;
    logic [47:0]  mStk [16];
    logic [1:0]   expPv;
    logic [95:0]  expPip;
    logic         expUf;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic modelStep();
        if (rst) begin
            mTos = 0; mCnt = 0; expPv = '0; expPip = '0; expUf = 1'b0;
        end else if (busIf.restore_en) begin
            mTos  = int'(busIf.restore_tos);
            mCnt  = (int'(busIf.restore_cnt) > 16) ? 16 : int'(busIf.restore_cnt);
            expPv = '0; expPip = '0; expUf = 1'b0;
        end else if (!busIf.stall) begin
            expPv = '0; expPip = '0; expUf = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (busIf.ln_vld[i]) begin
                    if (busIf.ln_pop[i]) begin
                        if (mCnt > 0) begin
                            expPv[i] = 1'b1;
                            expPip[i*48 +: 48] = mStk[mTos];
                            mTos = (mTos + 15) % 16;
                            mCnt = mCnt - 1;
                        end else begin
                            expUf = 1'b1;
                        end
                    end
                    if (busIf.ln_push[i]) begin
                        mTos = (mTos + 1) % 16;
                        mStk[mTos] = busIf.ln_ret_ip[i*48 +: 48];
                        if (mCnt < 16) mCnt = mCnt + 1;
                    end
                end
            end
        end
    endtask

    task automatic compareAll();
        chk("ckpt_tos",  96'(busIf.ckpt_tos),  96'(mTos));
        chk("ckpt_cnt",  96'(busIf.ckpt_cnt),  96'(mCnt));
        chk("pred_vld",  96'(busIf.pred_vld),  96'(expPv));
        chk("pred_ip",   busIf.pred_ip,        expPip);
        chk("underflow", 96'(busIf.underflow), 96'(expUf));
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic setIdle();
        busIf.stall       = 1'b0;
        busIf.ln_vld      = '0;
        busIf.ln_push     = '0;
        busIf.ln_pop      = '0;
        busIf.ln_ret_ip   = '0;
        busIf.restore_en  = 1'b0;
        busIf.restore_tos = '0;
        busIf.restore_cnt = '0;
    endtask

    task automatic setLane(input int i, input bit pu, input bit po, input logic [47:0] ip);
        busIf.ln_vld[i]            = 1'b1;
        busIf.ln_push[i]           = pu;
        busIf.ln_pop[i]            = po;
        busIf.ln_ret_ip[i*48 +: 48] = ip;
    endtask

    logic [PTR_W-1:0] savedTos;
    logic [CNT_W-1:0] savedCnt;
    logic [63:0]      rnd;

    initial begin
        nVec = 0;
        nErr = 0;
        mTos = 0; mCnt = 0; expPv = '0; expPip = '0; expUf = 1'b0;
        setIdle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_cnt", 96'(busIf.ckpt_cnt), 96'd0);
        chk("rst_vld", 96'(busIf.pred_vld), 96'd0);
        rst = 1'b0;

        // 1: push then pop
        setLane(0, 1'b1, 1'b0, 48'h1000); tick(); setIdle();
        chk("t1_cnt_after_push", 96'(busIf.ckpt_cnt), 96'd1);
        chk("t1_tos_after_push", 96'(busIf.ckpt_tos), 96'd1);
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t1_pred_vld", 96'(busIf.pred_vld), 96'h1);
        chk("t1_pred_ip0", 96'(busIf.pred_ip[47:0]), 96'h1000);
        chk("t1_cnt", 96'(busIf.ckpt_cnt), 96'd0);

        // 2: intra-cycle forwarding
        setLane(0, 1'b1, 1'b0, 48'h2000); setLane(1, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t2_pred_vld", 96'(busIf.pred_vld), 96'h2);
        chk("t2_pred_ip1", 96'(busIf.pred_ip[95:48]), 96'h2000);
        chk("t2_cnt", 96'(busIf.ckpt_cnt), 96'd0);

        // 3: overflow wrap then drain
        for (int k = 0; k < 17; k++) begin
            setLane(0, 1'b1, 1'b0, 48'(48'h100 + k)); tick(); setIdle();
        end
        chk("t3_cnt_sat", 96'(busIf.ckpt_cnt), 96'd16);
        for (int k = 0; k < 16; k++) begin
            setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
            chk("t3_pop_ip", 96'(busIf.pred_ip[47:0]), 96'(48'h110 - k));
        end
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t3_uf", 96'(busIf.underflow), 96'd1);
        chk("t3_uf_vld", 96'(busIf.pred_vld), 96'd0);

        // 4: pop on empty
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t4_uf", 96'(busIf.underflow), 96'd1);
        chk("t4_tos", 96'(busIf.ckpt_tos), 96'd1);

        // 5: checkpoint / restore
        for (int k = 1; k <= 3; k++) begin
            setLane(0, 1'b1, 1'b0, 48'(48'hA0 + k)); tick(); setIdle();
        end
        chk("t5_ck_tos", 96'(busIf.ckpt_tos), 96'd4);
        chk("t5_ck_cnt", 96'(busIf.ckpt_cnt), 96'd3);
        savedTos = busIf.ckpt_tos;
        savedCnt = busIf.ckpt_cnt;
        setLane(0, 1'b1, 1'b0, 48'hB1); setLane(1, 1'b1, 1'b0, 48'hB2); tick(); setIdle();
        for (int k = 0; k < 2; k++) begin
            setLane(0, 1'b0, 1'b1, 48'h0); setLane(1, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        end
        busIf.restore_en  = 1'b1;
        busIf.restore_tos = savedTos;
        busIf.restore_cnt = savedCnt;
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t5_rs_tos", 96'(busIf.ckpt_tos), 96'd4);
        chk("t5_rs_cnt", 96'(busIf.ckpt_cnt), 96'd3);
        chk("t5_rs_vld", 96'(busIf.pred_vld), 96'd0);
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("t5_pop_ip", 96'(busIf.pred_ip[47:0]), 96'hA3);

        // 6: stall holds, reset overrides stall
        busIf.stall = 1'b1; setLane(0, 1'b1, 1'b0, 48'hDEAD); tick();
        chk("t6_st_tos", 96'(busIf.ckpt_tos), 96'd3);
        chk("t6_st_cnt", 96'(busIf.ckpt_cnt), 96'd2);
        chk("t6_st_vld", 96'(busIf.pred_vld), 96'h1);
        rst = 1'b1; tick(); rst = 1'b0; setIdle();
        chk("t6_rst_tos", 96'(busIf.ckpt_tos), 96'd0);
        chk("t6_rst_cnt", 96'(busIf.ckpt_cnt), 96'd0);
        chk("t6_rst_ip", busIf.pred_ip, 96'd0);

        // restore clamp, same-lane push+pop, two-lane push then pop
        busIf.restore_en = 1'b1; busIf.restore_tos = 4'd5; busIf.restore_cnt = 5'd20; tick(); setIdle();
        chk("clamp_cnt", 96'(busIf.ckpt_cnt), 96'd16);
        setLane(0, 1'b1, 1'b1, 48'hBEEF); tick(); setIdle();
        chk("pp_cnt", 96'(busIf.ckpt_cnt), 96'd16);
        setLane(0, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("pp_ip", 96'(busIf.pred_ip[47:0]), 96'hBEEF);
        setLane(0, 1'b1, 1'b0, 48'hC1); setLane(1, 1'b1, 1'b0, 48'hC2); tick(); setIdle();
        setLane(0, 1'b0, 1'b1, 48'h0); setLane(1, 1'b0, 1'b1, 48'h0); tick(); setIdle();
        chk("dual_ip0", 96'(busIf.pred_ip[47:0]), 96'hC2);
        chk("dual_ip1", 96'(busIf.pred_ip[95:48]), 96'hC1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            setIdle();
            rst = ($urandom_range(0, 199) == 0);
            busIf.stall = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) begin
                busIf.restore_en  = 1'b1;
                busIf.restore_tos = 4'($urandom_range(0, 15));
                busIf.restore_cnt = 5'($urandom_range(0, 31));
            end
            for (int i = 0; i < 2; i++) begin
                rnd = {$urandom, $urandom};
                busIf.ln_vld[i]             = ($urandom_range(0, 3) != 0);
                busIf.ln_push[i]            = 1'($urandom_range(0, 1));
                busIf.ln_pop[i]             = 1'($urandom_range(0, 1));
                busIf.ln_ret_ip[i*48 +: 48] = rnd[47:0];
            end
            tick();
        end
        rst = 1'b0;
        setIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
